// File: rtl/sprite_pkg.sv
// Screen geometry, coordinate and colour types shared by the sprite blitter
// and its address generator.
package sprite_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // One bit wider than DrawX so position + extent sums never wrap.
    typedef logic [10:0] coord_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb444_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Stage-1 sprite geometry: bounds check against the scaled extent and
// ROM address build {frame, row, col}. Purely combinational.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W  = 64,
    parameter int SPR_H  = 64,
    parameter int FRAMES = 4,
    parameter int ADDR_W = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  coord_t                      draw_x,
    input  coord_t                      draw_y,
    input  coord_t                      pos_x,
    input  coord_t                      pos_y,
    input  logic [1:0]                  scale,
    input  logic                        flip_h,
    input  logic [$clog2(FRAMES)-1:0]   frame,
    output logic                        in_box,
    output logic [ADDR_W-1:0]           addr
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    coord_t           ew;
    coord_t           eh;
    coord_t           x_end;
    coord_t           y_end;
    coord_t           dx;
    coord_t           dy;
    logic [CW-1:0]    col_idx;
    logic [CW-1:0]    col_flip;
    logic [RW-1:0]    row_idx;

    always_comb begin
        ew    = coord_t'(SPR_W) << scale;
        eh    = coord_t'(SPR_H) << scale;
        x_end = pos_x + ew;
        y_end = pos_y + eh;
        dx    = draw_x - pos_x;
        dy    = draw_y - pos_y;

        // Clipping to the visible area keeps off-screen columns from ever
        // reaching the ROM, even while DrawX runs through horizontal blanking.
        in_box = (draw_x >= pos_x) && (draw_x < x_end) &&
                 (draw_y >= pos_y) && (draw_y < y_end) &&
                 (draw_x < coord_t'(H_ACTIVE)) && (draw_y < coord_t'(V_ACTIVE));

        col_idx  = CW'(dx >> scale);
        row_idx  = RW'(dy >> scale);
        // SPR_W is a power of two, so SPR_W-1-col is a bitwise inversion.
        col_flip = flip_h ? ~col_idx : col_idx;
        addr     = ADDR_W'({frame, row_idx, col_flip});
    end

endmodule

// File: rtl/sprite_blitter.sv
// Three-stage sprite overlay: shadow-latched placement, external sprite ROM
// and palette, transparent-index keying over a per-pixel background colour.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 64,
    parameter int FRAMES     = 4,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic                        vga_clk,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic                        blank,
    input  logic                        enable,
    input  logic [9:0]                  pos_x,
    input  logic [9:0]                  pos_y,
    input  logic [1:0]                  scale,
    input  logic                        flip_h,
    input  logic [$clog2(FRAMES)-1:0]   frame_sel,
    input  logic [3:0]                  bg_red,
    input  logic [3:0]                  bg_green,
    input  logic [3:0]                  bg_blue,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [IDX_W-1:0]            rom_q,
    output logic [IDX_W-1:0]            pal_index,
    input  logic [3:0]                  pal_red,
    input  logic [3:0]                  pal_green,
    input  logic [3:0]                  pal_blue,
    output logic [3:0]                  red,
    output logic [3:0]                  green,
    output logic [3:0]                  blue,
    output logic                        sprite_hit
);

    localparam int FSEL_W = $clog2(FRAMES);
    localparam logic [FSEL_W:0]   FRAME_LAST = (FSEL_W + 1)'(FRAMES - 1);
    localparam logic [IDX_W-1:0]  TRANSP     = IDX_W'(TRANSP_IDX);

    logic               en_sh_reg;
    coord_t             pos_x_sh_reg;
    coord_t             pos_y_sh_reg;
    logic [1:0]         scale_sh_reg;
    logic               flip_sh_reg;
    logic [FSEL_W-1:0]  frame_sh_reg;
    logic [FSEL_W-1:0]  frame_clamped;

    logic [ADDR_W-1:0]  addr_next;
    logic               in_box;

    logic [ADDR_W-1:0]  addr_reg;
    logic               box1_reg;
    logic               blank1_reg;
    rgb444_t            bg1_reg;
    logic               box2_reg;
    logic               blank2_reg;
    rgb444_t            bg2_reg;
    rgb444_t            rgb_reg;
    logic               hit_reg;

    rgb444_t            bg_in;
    rgb444_t            pal_in;
    rgb444_t            rgb_next;
    logic               hit_next;

    assign bg_in  = '{red: bg_red,  green: bg_green,  blue: bg_blue};
    assign pal_in = '{red: pal_red, green: pal_green, blue: pal_blue};

    assign frame_clamped = ({1'b0, frame_sel} > FRAME_LAST) ? FRAME_LAST[FSEL_W-1:0] : frame_sel;

    sprite_addr_gen #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .FRAMES (FRAMES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .draw_x (coord_t'({1'b0, DrawX})),
        .draw_y (coord_t'({1'b0, DrawY})),
        .pos_x  (pos_x_sh_reg),
        .pos_y  (pos_y_sh_reg),
        .scale  (scale_sh_reg),
        .flip_h (flip_sh_reg),
        .frame  (frame_sh_reg),
        .in_box (in_box),
        .addr   (addr_next)
    );

    always_comb begin
        hit_next = blank2_reg && box2_reg && (rom_q != TRANSP);
        rgb_next = bg2_reg;
        if (!blank2_reg) begin
            rgb_next = '0;
        end else if (hit_next) begin
            rgb_next = pal_in;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            en_sh_reg    <= 1'b0;
            pos_x_sh_reg <= '0;
            pos_y_sh_reg <= '0;
            scale_sh_reg <= '0;
            flip_sh_reg  <= 1'b0;
            frame_sh_reg <= '0;
            addr_reg     <= '0;
            box1_reg     <= 1'b0;
            blank1_reg   <= 1'b0;
            bg1_reg      <= '0;
            box2_reg     <= 1'b0;
            blank2_reg   <= 1'b0;
            bg2_reg      <= '0;
            rgb_reg      <= '0;
            hit_reg      <= 1'b0;
        end else begin
            // Shadow load and stage 1 share this edge, so a pixel arriving
            // with frame_tick is still drawn with the previous placement.
            if (frame_tick) begin
                en_sh_reg    <= enable;
                pos_x_sh_reg <= coord_t'({1'b0, pos_x});
                pos_y_sh_reg <= coord_t'({1'b0, pos_y});
                scale_sh_reg <= scale;
                flip_sh_reg  <= flip_h;
                frame_sh_reg <= frame_clamped;
            end
            if (in_box) begin
                addr_reg <= addr_next;
            end
            box1_reg   <= in_box && en_sh_reg;
            blank1_reg <= blank;
            bg1_reg    <= bg_in;
            box2_reg   <= box1_reg;
            blank2_reg <= blank1_reg;
            bg2_reg    <= bg1_reg;
            rgb_reg    <= rgb_next;
            hit_reg    <= hit_next;
        end
    end

    assign rom_addr   = addr_reg;
    assign pal_index  = rom_q;
    assign red        = rgb_reg.red;
    assign green      = rgb_reg.green;
    assign blue       = rgb_reg.blue;
    assign sprite_hit = hit_reg;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: directed pixels push expected address
// and colour entries; a monitor pops and compares them when they fall due.
module tb_sprite_blitter;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic        enable;
    logic [9:0]  pos_x, pos_y;
    logic [1:0]  scale;
    logic        flip_h;
    logic [1:0]  frame_sel;
    logic [3:0]  bg_red, bg_green, bg_blue;
    logic [13:0] rom_addr;
    logic [3:0]  rom_q = 4'h0;
    logic [3:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [3:0]  red, green, blue;
    logic        sprite_hit;

    typedef struct { int due; logic [13:0] addr; } addr_e;
    typedef struct { int due; logic [12:0] pix; } pix_e;   // {r,g,b,hit}

    addr_e addr_q[$];
    pix_e  pix_q[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    // Sprite ROM: index = column low nibble = address low nibble.
    always @(posedge vga_clk) rom_q <= rom_addr[3:0];
    assign pal_red   = pal_index;
    assign pal_green = 4'hF - pal_index;
    assign pal_blue  = pal_index ^ 4'h5;

    sprite_blitter dut (
        .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .enable(enable),
        .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .flip_h(flip_h),
        .frame_sel(frame_sel), .bg_red(bg_red), .bg_green(bg_green),
        .bg_blue(bg_blue), .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green),
        .pal_blue(pal_blue), .red(red), .green(green), .blue(blue),
        .sprite_hit(sprite_hit)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end else begin
            $display("ok   %s @cyc %0d: %0h", name, cyc, act);
        end
    endtask

    task automatic monitor();
        addr_e ae;
        pix_e  pe;
        forever begin
            @(negedge vga_clk);
            if (addr_q.size() != 0 && addr_q[0].due == cyc) begin
                ae = addr_q.pop_front();
                chk("rom_addr", 32'(rom_addr), 32'(ae.addr));
            end
            if (pix_q.size() != 0 && pix_q[0].due == cyc) begin
                pe = pix_q.pop_front();
                chk("rgb_hit", 32'({red, green, blue, sprite_hit}), 32'(pe.pix));
            end
        end
    endtask

    // One pixel per clock; expected address and hit are hand-computed by the caller.
    task automatic pix(input int x, input int y, input logic bl, input logic tick,
                       input int exp_addr, input logic exp_hit);
        logic [3:0]  idx;
        logic [11:0] rgb;
        addr_e       ae;
        pix_e        pe;
        @(posedge vga_clk);
        #1;
        DrawX = x[9:0];  DrawY = y[9:0];
        blank = bl;      frame_tick = tick;
        bg_red = 4'hA;   bg_green = x[3:0];   bg_blue = 4'h3;
        idx = exp_addr[3:0];
        if (!bl)         rgb = 12'h000;
        else if (exp_hit) rgb = {idx, 4'hF - idx, idx ^ 4'h5};
        else             rgb = {4'hA, x[3:0], 4'h3};
        ae.due = cyc + 1; ae.addr = exp_addr[13:0];
        pe.due = cyc + 3; pe.pix  = {rgb, exp_hit};
        addr_q.push_back(ae);
        pix_q.push_back(pe);
    endtask

    task automatic setup(input int px, input int py, input logic [1:0] sc,
                         input logic fl, input logic [1:0] fr);
        enable = 1'b1; pos_x = px[9:0]; pos_y = py[9:0];
        scale = sc; flip_h = fl; frame_sel = fr;
    endtask

    task automatic stimulus();
        int fs7 = 7;
        reset = 1'b1; frame_tick = 0; DrawX = 0; DrawY = 0; blank = 0;
        enable = 0; pos_x = 0; pos_y = 0; scale = 0; flip_h = 0; frame_sel = 0;
        bg_red = 0; bg_green = 0; bg_blue = 0;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset_addr", 32'(rom_addr), 32'd0);
        chk("reset_rgb", 32'({red, green, blue}), 32'd0);
        chk("reset_hit", 32'(sprite_hit), 32'd0);
        #1 reset = 1'b0;

        setup(100, 50, 2'd0, 1'b0, 2'd0);
        pix(10, 10, 1, 1, 650, 0);      // tick cycle uses reset shadow (pos 0,0, disabled)
        pix(100, 50, 1, 0, 0, 0);       // index 0 transparent
        pix(105, 50, 1, 0, 5, 1);
        pix(164, 50, 1, 0, 5, 0);       // right edge exclusive, address holds
        pix(163, 52, 1, 0, 191, 1);
        pix(120, 50, 0, 0, 20, 0);      // blanked
        pix(99, 50, 1, 0, 20, 0);
        pix(110, 113, 1, 0, 4042, 1);
        pix(110, 114, 1, 0, 4042, 0);

        pos_x = 10'd300; frame_sel = 2'd3;   // no tick yet
        pix(105, 50, 1, 0, 5, 1);
        pix(105, 50, 1, 1, 5, 1);
        pix(105, 50, 1, 0, 5, 0);
        pix(305, 50, 1, 0, 12293, 1);

        setup(0, 0, 2'd2, 1'b1, fs7[1:0]);   // frame 7 narrows to the last frame
        pix(0, 0, 1, 1, 12293, 0);
        pix(4, 8, 1, 0, 12478, 1);
        pix(0, 0, 1, 0, 12351, 1);
        pix(255, 255, 1, 0, 16320, 0);
        pix(256, 0, 1, 0, 16320, 0);

        setup(600, 0, 2'd1, 1'b0, 2'd0);
        pix(0, 0, 1, 1, 12351, 1);
        pix(600, 0, 1, 0, 0, 0);
        pix(601, 0, 1, 0, 0, 0);
        pix(602, 0, 1, 0, 1, 1);
        pix(639, 0, 1, 0, 19, 1);
        pix(640, 0, 1, 0, 19, 0);
        pix(0, 0, 1, 0, 19, 0);
        pix(639, 127, 1, 0, 4051, 1);
        pix(639, 128, 1, 0, 4051, 0);

        setup(0, 0, 2'd0, 1'b0, 2'd0);
        pix(700, 500, 0, 1, 4051, 0);
        pix(5, 0, 1, 0, 5, 1);
        pix(6, 0, 1, 0, 6, 1);
        pix(7, 0, 1, 0, 7, 1);
        pix(700, 500, 0, 0, 7, 0);

        // Asynchronous reset in the middle of a visible run.
        @(posedge vga_clk);
        #2 reset = 1'b1;
        #1;
        addr_q.delete();
        pix_q.delete();
        chk("midrst_addr", 32'(rom_addr), 32'd0);
        chk("midrst_rgb", 32'({red, green, blue}), 32'd0);
        chk("midrst_hit", 32'(sprite_hit), 32'd0);
        @(posedge vga_clk);
        #1;
        chk("rsthold_rgb", 32'({red, green, blue, sprite_hit}), 32'd0);
        #1 reset = 1'b0;

        pix(5, 0, 0, 0, 5, 0);
        pix(5, 0, 1, 0, 5, 0);          // shadow enable cleared by reset
        pix(6, 0, 1, 1, 6, 0);
        pix(7, 0, 1, 0, 7, 1);
        pix(8, 0, 0, 0, 8, 0);
        pix(9, 0, 1, 0, 9, 1);
        pix(700, 500, 0, 0, 9, 0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        stimulus();
        for (int i = 0; i < 20 && (addr_q.size() != 0 || pix_q.size() != 0); i++)
            @(posedge vga_clk);
        if (addr_q.size() != 0 || pix_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries still pending, required 0", addr_q.size() + pix_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
